// File: rtl/mem_access_stage.sv
// RV32 memory-access stage over a req/ack data bus; optional `MISALIGN_TRAP_EN traps misaligned accesses.
// Latency: 1 cycle for non-memory ops, 1 + N bus cycles for loads/stores (2 minimum).
// Backpressure: mem_stall holds upstream stages until ack or bus timeout (BUS_TIMEOUT, 0 = never).
module mem_access_stage #(
   parameter int unsigned BUS_TIMEOUT = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] EX_MEM_ALU_result,
   input  logic [31:0] EX_MEM_WriteData,
   input  logic [31:0] EX_MEM_pcPlus4,
   input  logic [4:0]  EX_MEM_rd,
   input  logic [2:0]  EX_MEM_funct3,
   input  logic [1:0]  EX_MEM_ResultSrc,
   input  logic        EX_MEM_RegWrite,
   input  logic        EX_MEM_MemRead,
   input  logic        EX_MEM_MemWrite,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        mem_stall,
   output logic        mem_bus_err,
   output logic        mem_misalign,
   output logic        MEM_WB_RegWrite,
   output logic [4:0]  MEM_WB_rd,
   output logic [31:0] MEM_WB_result
);

   typedef enum logic {IDLE, BUS} state_t;

   state_t      state;
   logic [31:0] tmo_cnt;

   logic        acc, is_byte, is_half, trap, ack_ok, tmo_hit;
   logic [31:0] eff_addr, shifted, load_data, wb_mux, wdata_nxt;
   logic [1:0]  offs;
   logic [3:0]  be_nxt;

   always_comb begin
      acc      = EX_MEM_MemRead | EX_MEM_MemWrite;
      is_byte  = (EX_MEM_funct3[1:0] == 2'b00);
      is_half  = (EX_MEM_funct3[1:0] == 2'b01);
      eff_addr = EX_MEM_ALU_result;
`ifdef MISALIGN_TRAP_EN
      trap = acc && (is_half ? EX_MEM_ALU_result[0]
                             : (!is_byte && (EX_MEM_ALU_result[1:0] != 2'b00)));
`else
      trap = 1'b0;
      // Misaligned accesses are silently aligned down to their natural size.
      if (is_half)
         eff_addr[0] = 1'b0;
      else if (!is_byte)
         eff_addr[1:0] = 2'b00;
`endif
      offs    = eff_addr[1:0];
      shifted = dmem_rdata >> {offs, 3'b000};

      case (EX_MEM_funct3)
         3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
         3'b100:  load_data = {24'd0, shifted[7:0]};
         3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
         3'b101:  load_data = {16'd0, shifted[15:0]};
         default: load_data = shifted;
      endcase

      case (EX_MEM_ResultSrc)
         2'b01:   wb_mux = load_data;
         2'b10:   wb_mux = EX_MEM_pcPlus4;
         default: wb_mux = EX_MEM_ALU_result;
      endcase

      if (is_byte) begin
         be_nxt    = 4'b0001 << offs;
         wdata_nxt = {4{EX_MEM_WriteData[7:0]}};
      end else if (is_half) begin
         be_nxt    = 4'b0011 << {offs[1], 1'b0};
         wdata_nxt = {2{EX_MEM_WriteData[15:0]}};
      end else begin
         be_nxt    = 4'b1111;
         wdata_nxt = EX_MEM_WriteData;
      end

      ack_ok  = dmem_req && dmem_ack;
      tmo_hit = (BUS_TIMEOUT != 0) && ((tmo_cnt + 32'd1) == BUS_TIMEOUT);

      mem_stall = 1'b0;
      if (!rst) begin
         if (state == IDLE)
            mem_stall = acc && !trap;
         else
            mem_stall = !ack_ok && !tmo_hit;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         tmo_cnt         <= 32'd0;
         dmem_req        <= 1'b0;
         dmem_we         <= 1'b0;
         dmem_addr       <= 32'd0;
         dmem_wdata      <= 32'd0;
         dmem_be         <= 4'd0;
         mem_bus_err     <= 1'b0;
         mem_misalign    <= 1'b0;
         MEM_WB_RegWrite <= 1'b0;
         MEM_WB_rd       <= 5'd0;
         MEM_WB_result   <= 32'd0;
      end else begin
         mem_bus_err  <= 1'b0;
         mem_misalign <= 1'b0;
         case (state)
            IDLE: begin
               if (acc && !trap) begin
                  dmem_req        <= 1'b1;
                  dmem_we         <= EX_MEM_MemWrite;
                  dmem_addr       <= {eff_addr[31:2], 2'b00};
                  dmem_be         <= be_nxt;
                  dmem_wdata      <= wdata_nxt;
                  tmo_cnt         <= 32'd0;
                  state           <= BUS;
                  MEM_WB_RegWrite <= 1'b0;
                  MEM_WB_rd       <= 5'd0;
                  MEM_WB_result   <= 32'd0;
               end else if (trap) begin
                  mem_misalign    <= 1'b1;
                  MEM_WB_RegWrite <= 1'b0;
                  MEM_WB_rd       <= 5'd0;
                  MEM_WB_result   <= 32'd0;
               end else begin
                  MEM_WB_RegWrite <= EX_MEM_RegWrite;
                  MEM_WB_rd       <= EX_MEM_rd;
                  MEM_WB_result   <= wb_mux;
               end
            end
            BUS: begin
               // EX_MEM is frozen by mem_stall, so live inputs still describe this access.
               if (ack_ok) begin
                  dmem_req        <= 1'b0;
                  state           <= IDLE;
                  MEM_WB_RegWrite <= EX_MEM_RegWrite;
                  MEM_WB_rd       <= EX_MEM_rd;
                  MEM_WB_result   <= wb_mux;
               end else if (tmo_hit) begin
                  dmem_req        <= 1'b0;
                  state           <= IDLE;
                  mem_bus_err     <= 1'b1;
                  MEM_WB_RegWrite <= 1'b0;
                  MEM_WB_rd       <= 5'd0;
                  MEM_WB_result   <= 32'd0;
               end else begin
                  tmo_cnt <= tmo_cnt + 32'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage built with BUS_TIMEOUT = 4; the bench acts as the bus slave.
module tb_mem_access_stage;

   logic        clk, rst;
   logic [31:0] alu_result, write_data, pc_plus4;
   logic [4:0]  rd;
   logic [2:0]  funct3;
   logic [1:0]  result_src;
   logic        reg_write, mem_read, mem_write;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        mem_stall, mem_bus_err, mem_misalign;
   logic        wb_regwrite;
   logic [4:0]  wb_rd;
   logic [31:0] wb_result;

   int tests  = 0;
   int failed = 0;

   mem_access_stage #(.BUS_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .EX_MEM_ALU_result(alu_result), .EX_MEM_WriteData(write_data),
      .EX_MEM_pcPlus4(pc_plus4), .EX_MEM_rd(rd), .EX_MEM_funct3(funct3),
      .EX_MEM_ResultSrc(result_src), .EX_MEM_RegWrite(reg_write),
      .EX_MEM_MemRead(mem_read), .EX_MEM_MemWrite(mem_write),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
      .dmem_ack(dmem_ack), .mem_stall(mem_stall), .mem_bus_err(mem_bus_err),
      .mem_misalign(mem_misalign), .MEM_WB_RegWrite(wb_regwrite),
      .MEM_WB_rd(wb_rd), .MEM_WB_result(wb_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ex(input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc4,
                         input logic [4:0] r, input logic [2:0] f3, input logic [1:0] rs,
                         input logic rw, input logic mr, input logic mw);
      alu_result = a; write_data = wd; pc_plus4 = pc4; rd = r; funct3 = f3;
      result_src = rs; reg_write = rw; mem_read = mr; mem_write = mw;
   endtask

   task automatic nop();
      set_ex(32'd0, 32'd0, 32'd0, 5'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'd0;
      set_ex(32'h100, 32'h0, 32'h0, 5'd3, 3'b010, 2'b01, 1'b1, 1'b1, 1'b0);
      #12;
      tests++; if (mem_stall !== 1'b0) begin failed++; $display("FAIL reset_stall: got %b want 0", mem_stall); end
      tests++; if (dmem_req !== 1'b0) begin failed++; $display("FAIL reset_req: got %b want 0", dmem_req); end
      tests++; if ({wb_regwrite, wb_rd, wb_result} !== 38'd0) begin failed++; $display("FAIL reset_wb: got %b/%0d/%h want 0", wb_regwrite, wb_rd, wb_result); end
      nop();
      #2 rst = 1'b0;
      step();
   endtask

   task automatic test_nonmem();
      set_ex(32'h1234_5678, 32'h0, 32'h0000_0020, 5'd9, 3'b000, 2'b11, 1'b1, 1'b0, 1'b0);
      #1;
      tests++; if (mem_stall !== 1'b0) begin failed++; $display("FAIL alu_stall: got %b want 0", mem_stall); end
      step();
      tests++; if (wb_result !== 32'h1234_5678 || wb_rd !== 5'd9 || wb_regwrite !== 1'b1) begin failed++; $display("FAIL alu_wb: got %h rd %0d rw %b want 12345678 rd 9 rw 1", wb_result, wb_rd, wb_regwrite); end
      nop();
   endtask

   task automatic test_lw_zero_wait();
      set_ex(32'h100, 32'h0, 32'h0, 5'd5, 3'b010, 2'b01, 1'b1, 1'b1, 1'b0);
      #1;
      tests++; if (mem_stall !== 1'b1 || dmem_req !== 1'b0) begin failed++; $display("FAIL lw_issue: stall %b req %b want 1 0", mem_stall, dmem_req); end
      step();
      tests++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h100 || dmem_be !== 4'b1111 || dmem_we !== 1'b0) begin failed++; $display("FAIL lw_bus: req %b addr %h be %b we %b want 1 100 1111 0", dmem_req, dmem_addr, dmem_be, dmem_we); end
      dmem_rdata = 32'hDEAD_BEEF; dmem_ack = 1'b1;
      #1;
      tests++; if (mem_stall !== 1'b0) begin failed++; $display("FAIL lw_ack_stall: got %b want 0", mem_stall); end
      step();
      dmem_ack = 1'b0; nop();
      tests++; if (wb_result !== 32'hDEAD_BEEF || wb_regwrite !== 1'b1 || wb_rd !== 5'd5 || dmem_req !== 1'b0) begin failed++; $display("FAIL lw_wb: got %h rw %b rd %0d req %b want deadbeef 1 5 0", wb_result, wb_regwrite, wb_rd, dmem_req); end
   endtask

   task automatic test_lb_lbu();
      logic [2:0]  f3s  [2] = '{3'b000, 3'b100};
      logic [31:0] want [2] = '{32'hFFFF_FF80, 32'h0000_0080};
      for (int i = 0; i < 2; i++) begin
         set_ex(32'h203, 32'h0, 32'h0, 5'd6, f3s[i], 2'b01, 1'b1, 1'b1, 1'b0);
         step();
         tests++; if (dmem_be !== 4'b1000 || dmem_addr !== 32'h200) begin failed++; $display("FAIL lb_bus[%0d]: be %b addr %h want 1000 200", i, dmem_be, dmem_addr); end
         dmem_rdata = 32'h80FF_0011; dmem_ack = 1'b1;
         step();
         dmem_ack = 1'b0; nop();
         tests++; if (wb_result !== want[i]) begin failed++; $display("FAIL lb_data[%0d]: got %h want %h", i, wb_result, want[i]); end
      end
   endtask

   task automatic test_sh_wait();
      set_ex(32'h302, 32'h0000_ABCD, 32'h0, 5'd0, 3'b001, 2'b00, 1'b0, 1'b0, 1'b1);
      step();
      for (int c = 1; c <= 4; c++) begin
         if (c == 4) dmem_ack = 1'b1;
         #1;
         tests++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_wdata !== 32'hABCD_ABCD || dmem_be !== 4'b1100 || dmem_addr !== 32'h300) begin failed++; $display("FAIL sh_bus[%0d]: req %b we %b wdata %h be %b addr %h", c, dmem_req, dmem_we, dmem_wdata, dmem_be, dmem_addr); end
         tests++; if (mem_stall !== (c != 4)) begin failed++; $display("FAIL sh_stall[%0d]: got %b want %b", c, mem_stall, c != 4); end
         step();
      end
      dmem_ack = 1'b0; nop();
      tests++; if (wb_regwrite !== 1'b0 || dmem_req !== 1'b0 || mem_bus_err !== 1'b0) begin failed++; $display("FAIL sh_done: rw %b req %b err %b want 0 0 0", wb_regwrite, dmem_req, mem_bus_err); end
   endtask

   task automatic test_timeout();
      int req_cycles = 0;
      set_ex(32'h400, 32'h0, 32'h0, 5'd7, 3'b010, 2'b01, 1'b1, 1'b1, 1'b0);
      step();
      for (int c = 1; c <= 4; c++) begin
         if (dmem_req === 1'b1) req_cycles++;
         tests++; if (mem_stall !== (c != 4)) begin failed++; $display("FAIL tmo_stall[%0d]: got %b want %b", c, mem_stall, c != 4); end
         step();
      end
      set_ex(32'd7, 32'h0, 32'h0, 5'd8, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0);
      tests++; if (req_cycles != 4 || dmem_req !== 1'b0) begin failed++; $display("FAIL tmo_req: high %0d cycles, now %b want 4 then 0", req_cycles, dmem_req); end
      tests++; if (mem_bus_err !== 1'b1 || wb_regwrite !== 1'b0) begin failed++; $display("FAIL tmo_err: err %b rw %b want 1 0", mem_bus_err, wb_regwrite); end
      step();
      nop();
      tests++; if (mem_bus_err !== 1'b0 || wb_result !== 32'd7 || wb_regwrite !== 1'b1 || wb_rd !== 5'd8) begin failed++; $display("FAIL tmo_add: err %b res %h rw %b rd %0d want 0 7 1 8", mem_bus_err, wb_result, wb_regwrite, wb_rd); end
   endtask

   task automatic test_misalign();
      set_ex(32'h101, 32'h0, 32'h0, 5'd4, 3'b010, 2'b01, 1'b1, 1'b1, 1'b0);
`ifdef MISALIGN_TRAP_EN
      #1;
      tests++; if (mem_stall !== 1'b0) begin failed++; $display("FAIL mis_stall: got %b want 0", mem_stall); end
      step();
      nop();
      tests++; if (dmem_req !== 1'b0 || mem_misalign !== 1'b1 || wb_regwrite !== 1'b0) begin failed++; $display("FAIL mis_trap: req %b mis %b rw %b want 0 1 0", dmem_req, mem_misalign, wb_regwrite); end
      step();
      tests++; if (mem_misalign !== 1'b0) begin failed++; $display("FAIL mis_pulse: got %b want 0", mem_misalign); end
`else
      step();
      tests++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h100 || dmem_be !== 4'b1111 || mem_misalign !== 1'b0) begin failed++; $display("FAIL mis_align: req %b addr %h be %b mis %b want 1 100 1111 0", dmem_req, dmem_addr, dmem_be, mem_misalign); end
      dmem_rdata = 32'h1122_3344; dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0; nop();
      tests++; if (wb_result !== 32'h1122_3344 || wb_regwrite !== 1'b1) begin failed++; $display("FAIL mis_data: got %h rw %b want 11223344 1", wb_result, wb_regwrite); end
`endif
   endtask

   task automatic test_reset_mid_bus();
      set_ex(32'h504, 32'h0, 32'h0, 5'd2, 3'b010, 2'b01, 1'b1, 1'b1, 1'b0);
      step();
      step();
      tests++; if (dmem_req !== 1'b1 || mem_stall !== 1'b1) begin failed++; $display("FAIL rstbus_pre: req %b stall %b want 1 1", dmem_req, mem_stall); end
      #2 rst = 1'b1;
      #1;
      tests++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || dmem_addr !== 32'd0 || dmem_be !== 4'd0) begin failed++; $display("FAIL rstbus_now: req %b stall %b addr %h be %b want 0", dmem_req, mem_stall, dmem_addr, dmem_be); end
      step();
      nop();
      #2 rst = 1'b0;
      tests++; if (wb_regwrite !== 1'b0 || wb_result !== 32'd0) begin failed++; $display("FAIL rstbus_wb: rw %b res %h want 0 0", wb_regwrite, wb_result); end
      set_ex(32'h0000_0100, 32'h0, 32'h44, 5'd1, 3'b000, 2'b10, 1'b1, 1'b0, 1'b0);
      step();
      nop();
      tests++; if (wb_result !== 32'h44 || wb_regwrite !== 1'b1 || wb_rd !== 5'd1) begin failed++; $display("FAIL jal_wb: res %h rw %b rd %0d want 44 1 1", wb_result, wb_regwrite, wb_rd); end
   endtask

   initial begin
      test_reset();
      test_nonmem();
      test_lw_zero_wait();
      test_lb_lbu();
      test_sh_wait();
      test_timeout();
      test_misalign();
      test_reset_mid_bus();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
